// File: rtl/rf_op_sequencer_pkg.sv
// Shared definitions for the register-file operation sequencer: default widths,
// ALU opcodes and the sequencer FSM state encoding.
package rf_op_sequencer_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/rf_op_sequencer_alu.sv
// Combinational ALU for the sequencer. Produces a DW+1 bit result whose top bit is
// the carry for ADD, the borrow for SUB, and zero for every other operation.
module rf_op_sequencer_alu
  import rf_op_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW:0]   result
);

  // Select the operation; zero-extended operands make bit DW the carry/borrow.
  always_comb begin
    result = '0;
    case (op)
      OP_PASS: result = {1'b0, a};
      OP_ADD:  result = {1'b0, a} + {1'b0, b};
      OP_SUB:  result = {1'b0, a} - {1'b0, b};
      OP_AND:  result = {1'b0, a & b};
      OP_OR:   result = {1'b0, a | b};
      OP_XOR:  result = {1'b0, a ^ b};
      OP_LDI:  result = {1'b0, imm};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Initiator side of the 8x16 register file. Accepts one ALU command per handshake,
// reads both operands, computes the result and issues one write-back; CLR sweeps
// zeros into every register, one per cycle. All outputs are registered.
module rf_op_sequencer
  import rf_op_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] R_Adr,
  output logic [AW-1:0] S_Adr,
  input  logic [DW-1:0] R,
  input  logic [DW-1:0] S,
  output logic [AW-1:0] W_Adr,
  output logic          we,
  output logic [DW-1:0] W,
  output logic          done,
  output logic          zf,
  output logic          cf
);

  localparam logic [AW-1:0] LAST_ADR = '1;

  state_t        state, state_nx;
  logic          accept;
  logic          cmd_ready_nx, we_nx, done_nx, zf_nx, cf_nx;
  logic [AW-1:0] r_adr_nx, s_adr_nx, w_adr_nx;
  logic [AW-1:0] clr_cnt, clr_cnt_nx;
  logic [DW-1:0] w_nx;

  logic [2:0]    op_p0;
  logic [AW-1:0] dst_p0;
  logic [DW-1:0] imm_p0;
  logic [DW-1:0] opa_p1, opb_p1;
  logic [DW:0]   alu_res;

  function automatic logic is_zero(input logic [DW-1:0] v);
    return (v == '0);
  endfunction

  assign accept = cmd_valid & cmd_ready;

  rf_op_sequencer_alu #(.DW(DW)) u_alu (
    .op     (op_p0),
    .a      (opa_p1),
    .b      (opb_p1),
    .imm    (imm_p0),
    .result (alu_res)
  );

  // Stage p0: latch the command fields at the accept edge.
  // Stage p1: capture both read ports once the addresses have been presented.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= cmd_op;
      dst_p0 <= cmd_dst;
      imm_p0 <= cmd_imm;
    end
    if (state == ST_READ) begin
      opa_p1 <= R;
      opb_p1 <= S;
    end
  end

  // Next-state and next-output logic; outputs hold by default, strobes default low.
  always_comb begin
    state_nx     = state;
    cmd_ready_nx = cmd_ready;
    we_nx        = 1'b0;
    done_nx      = 1'b0;
    zf_nx        = zf;
    cf_nx        = cf;
    r_adr_nx     = R_Adr;
    s_adr_nx     = S_Adr;
    w_adr_nx     = W_Adr;
    w_nx         = W;
    clr_cnt_nx   = clr_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cmd_ready_nx = 1'b0;
          if (cmd_op == OP_CLR) begin
            state_nx   = ST_CLEAR;
            clr_cnt_nx = '0;
            we_nx      = 1'b1;
            w_adr_nx   = '0;
            w_nx       = '0;
          end else begin
            state_nx = ST_READ;
            r_adr_nx = cmd_srca;
            s_adr_nx = cmd_srcb;
          end
        end
      end
      ST_READ: begin
        state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        state_nx = ST_WRITE;
        we_nx    = 1'b1;
        done_nx  = 1'b1;
        w_adr_nx = dst_p0;
        w_nx     = alu_res[DW-1:0];
        zf_nx    = is_zero(alu_res[DW-1:0]);
        cf_nx    = alu_res[DW];
      end
      ST_WRITE: begin
        state_nx     = ST_IDLE;
        cmd_ready_nx = 1'b1;
      end
      ST_CLEAR: begin
        // The counter wraps 7->0 on the last write and is not used again.
        clr_cnt_nx = clr_cnt + AW'(1);
        if (clr_cnt == LAST_ADR) begin
          state_nx     = ST_IDLE;
          cmd_ready_nx = 1'b1;
          zf_nx        = 1'b1;
          cf_nx        = 1'b0;
        end else begin
          we_nx    = 1'b1;
          w_adr_nx = clr_cnt_nx;
          done_nx  = (clr_cnt_nx == LAST_ADR);
        end
      end
      default: begin
        state_nx     = ST_IDLE;
        cmd_ready_nx = 1'b1;
      end
    endcase
  end

  // Control and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      we        <= 1'b0;
      done      <= 1'b0;
      zf        <= 1'b0;
      cf        <= 1'b0;
      R_Adr     <= '0;
      S_Adr     <= '0;
      W_Adr     <= '0;
      W         <= '0;
      clr_cnt   <= '0;
    end else begin
      state     <= state_nx;
      cmd_ready <= cmd_ready_nx;
      we        <= we_nx;
      done      <= done_nx;
      zf        <= zf_nx;
      cf        <= cf_nx;
      R_Adr     <= r_adr_nx;
      S_Adr     <= s_adr_nx;
      W_Adr     <= w_adr_nx;
      W         <= w_nx;
      clr_cnt   <= clr_cnt_nx;
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer with an attached 8x16 register file. Stimulus pushes the
// expected write-backs into a queue; a monitor pops and checks every write it sees.
module tb_rf_op_sequencer;
  import rf_op_sequencer_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_dst = '0, cmd_srca = '0, cmd_srcb = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [AW-1:0] R_Adr, S_Adr, W_Adr;
  logic [DW-1:0] R, S, W;
  logic          we, done, zf, cf;

  typedef struct {
    logic [2:0]  adr;
    logic [15:0] data;
    logic        done;
    logic        chk_f;
    logic        zf;
    logic        cf;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] rf [8];
  logic [15:0] rf_exp [8];

  rf_op_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_imm(cmd_imm), .R_Adr(R_Adr), .S_Adr(S_Adr), .R(R), .S(S),
    .W_Adr(W_Adr), .we(we), .W(W), .done(done), .zf(zf), .cf(cf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: combinational reads, write at the edge while we is high.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (we) begin
      rf[W_Adr] <= W;
    end
  end
  assign R = rf[R_Adr];
  assign S = rf[S_Adr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (we) begin
        if (q.size() == 0) begin
          chk("unexpected_write", 32'(we), 32'(0));
        end else begin
          e = q.pop_front();
          chk("w_adr", 32'(W_Adr), 32'(e.adr));
          chk("w_data", 32'(W), 32'(e.data));
          chk("done", 32'(done), 32'(e.done));
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
          if (e.chk_f) begin
            chk("zf", 32'(zf), 32'(e.zf));
            chk("cf", 32'(cf), 32'(e.cf));
          end
        end
      end else if (done) begin
        chk("done_without_we", 32'(done), 32'(0));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 30);
    chk("ready_timeout", 32'(cmd_ready), 32'(1));
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [2:0] sb, input logic [15:0] imm);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_srca  = sa;
    cmd_srcb  = sb;
    cmd_imm   = imm;
  endtask

  // Queue the writes a command accepted at the edge after cycle 'base' must produce.
  task automatic expect_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [15:0] w,
                            input logic ezf, input logic ecf, input int base);
    exp_t e;
    if (op == OP_CLR) begin
      for (int k = 0; k < 8; k++) begin
        e.adr = 3'(k); e.data = '0; e.done = (k == 7); e.chk_f = 1'b0;
        e.zf = 1'b0; e.cf = 1'b0; e.cyc = base + 1 + k;
        q.push_back(e);
      end
    end else begin
      e.adr = dst; e.data = w; e.done = 1'b1; e.chk_f = 1'b1;
      e.zf = ezf; e.cf = ecf; e.cyc = base + 3;
      q.push_back(e);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [2:0] sb, input logic [15:0] imm, input logic [15:0] w,
                       input logic ezf, input logic ecf);
    wait_idle();
    drive(op, dst, sa, sb, imm);
    expect_cmd(op, dst, w, ezf, ecf, cyc);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), 32'(rf[i]), 32'(rf_exp[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  t_op [12];
    logic [2:0]  t_dst [12];
    logic [2:0]  t_sa [12];
    logic [2:0]  t_sb [12];
    logic [15:0] t_imm [12];
    logic [15:0] t_w [12];

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'(1));
    chk("rst_we", 32'(we), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_zf", 32'(zf), 32'(0));
    chk("rst_cf", 32'(cf), 32'(0));
    chk("rst_adrs", 32'({R_Adr, S_Adr, W_Adr}), 32'(0));
    chk("rst_w", 32'(W), 32'(0));

    // CLR sweep, then flags.
    issue(OP_CLR, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    wait_idle();
    chk("clr_zf", 32'(zf), 32'(1));
    chk("clr_cf", 32'(cf), 32'(0));

    // Arithmetic vectors with hand-computed results and flags.
    issue(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    issue(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0,    16'h8000, 1'b0, 1'b0);
    issue(OP_LDI, 3'd4, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    issue(OP_ADD, 3'd5, 3'd4, 3'd2, 16'h0,    16'h0000, 1'b1, 1'b1);
    issue(OP_SUB, 3'd6, 3'd2, 3'd4, 16'h0,    16'h0002, 1'b0, 1'b1);
    issue(OP_XOR, 3'd7, 3'd3, 3'd3, 16'h0,    16'h0000, 1'b1, 1'b0);
    issue(OP_AND, 3'd3, 3'd3, 3'd4, 16'h0,    16'h8000, 1'b0, 1'b0);
    issue(OP_OR,  3'd0, 3'd1, 3'd2, 16'h0,    16'h7FFF, 1'b0, 1'b0);
    issue(OP_PASS,3'd0, 3'd6, 3'd1, 16'h0,    16'h0002, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_zf", 32'(zf), 32'(0));
    chk("hold_cf", 32'(cf), 32'(0));
    rf_exp = '{16'h0002, 16'h7FFF, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h0002, 16'h0000};
    check_rf("alu");

    // Continuous valid with changing fields: only rows 0, 4 and 8 land.
    t_op  = '{OP_LDI, OP_CLR, OP_XOR, OP_ADD, OP_ADD, OP_CLR, OP_LDI, OP_SUB,
              OP_SUB, OP_CLR, OP_LDI, OP_OR};
    t_dst = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd6, 3'd7, 3'd1, 3'd3, 3'd0, 3'd2, 3'd4, 3'd2};
    t_sa  = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd5, 3'd7, 3'd0, 3'd4, 3'd1, 3'd3, 3'd0, 3'd1};
    t_sb  = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd5, 3'd7, 3'd0, 3'd2, 3'd5, 3'd3, 3'd0, 3'd4};
    t_imm = '{16'h1234, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'hAAAA, 16'hDEAD, 16'h0,
              16'h0, 16'h5555, 16'hBEEF, 16'h0};
    t_w   = '{16'h1234, 16'h0, 16'h0, 16'h0, 16'h2468, 16'h0, 16'h0, 16'h0,
              16'h6DCB, 16'h0, 16'h0, 16'h0};
    wait_idle();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("stream_ready_%0d", i), 32'(cmd_ready), 32'((i % 4) == 0));
      drive(t_op[i], t_dst[i], t_sa[i], t_sb[i], t_imm[i]);
      if ((i % 4) == 0) expect_cmd(t_op[i], t_dst[i], t_w[i], 1'b0, 1'b0, cyc);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    rf_exp = '{16'h6DCB, 16'h7FFF, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h2468, 16'h0000};
    check_rf("stream");

    // Set both flags, then reset during EXEC of an ADD.
    issue(OP_ADD, 3'd7, 3'd4, 3'd2, 16'h0, 16'h0000, 1'b1, 1'b1);
    wait_idle();
    drive(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_exec_we", 32'(we), 32'(0));
    chk("rst_exec_done", 32'(done), 32'(0));
    chk("rst_exec_ready", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_exec_zf", 32'(zf), 32'(0));
    chk("rst_exec_cf", 32'(cf), 32'(0));
    rf_exp = '{default: 16'h0};
    check_rf("rst_exec");
    issue(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h00AA, 16'h00AA, 1'b0, 1'b0);

    // Reset during CLEAR with the counter at 3: only writes 0..2 are seen.
    wait_idle();
    drive(OP_CLR, 3'd0, 3'd0, 3'd0, 16'h0);
    begin
      exp_t e;
      for (int k = 0; k < 3; k++) begin
        e.adr = 3'(k); e.data = '0; e.done = 1'b0; e.chk_f = 1'b0;
        e.zf = 1'b0; e.cf = 1'b0; e.cyc = cyc + 1 + k;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("clr_cnt3_adr", 32'(W_Adr), 32'(3));
    reset = 1'b1;
    #1;
    chk("rst_clr_we", 32'(we), 32'(0));
    chk("rst_clr_ready", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_clr_ready_after", 32'(cmd_ready), 32'(1));
    chk("rst_clr_zf", 32'(zf), 32'(0));
    chk("rst_clr_cf", 32'(cf), 32'(0));
    check_rf("rst_clr");
    chk("pending_writes", 32'(q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
